// File: rtl/data_memory_pkg.sv
// Shared types and limits for the data_memory block.
// Sequencer state enum and read-latency range helpers.
package data_memory_pkg;

    typedef enum logic {
        CLEAR,
        RUN
    } seq_state_t;

    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 4;

    function automatic int clamp_lat(input int lat);
        if (lat < READ_LAT_MIN) return READ_LAT_MIN;
        if (lat > READ_LAT_MAX) return READ_LAT_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/mem_read_pipe.sv
// LAT-stage data/valid delay line for read responses.
// Data registers only load behind a valid, so the output holds between pulses.
module mem_read_pipe #(
    parameter int W   = 8,
    parameter int LAT = 1
) (
    input  logic         clock,
    input  logic         resetN,
    input  logic         req_valid,
    input  logic [W-1:0] req_data,
    output logic         rsp_valid,
    output logic [W-1:0] rsp_data
);

    logic [LAT-1:0] vld;
    logic [W-1:0]   dat [LAT];

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            vld <= '0;
            for (int i = 0; i < LAT; i++) dat[i] <= '0;
        end else begin
            vld[0] <= req_valid;
            if (req_valid) dat[0] <= req_data;
            for (int i = 1; i < LAT; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) dat[i] <= dat[i-1];
            end
        end
    end

    assign rsp_valid = vld[LAT-1];
    assign rsp_data  = dat[LAT-1];

endmodule

// File: rtl/data_memory.sv
// Single-port byte-writable data memory with pipelined reads.
// DATA_MEMORY_CLEAR_EN: zero-fill sequencer runs after every reset.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 13,
    parameter int READ_LAT = 1
) (
    input  logic                clock,
    input  logic                resetN,
    input  logic                memReq,
    input  logic                memWrite,
    input  logic [ADDR_W-1:0]   addressMem,
    input  logic [DATA_W-1:0]   dataMem,
    input  logic [DATA_W/8-1:0] byteEn,
    output logic                memReady,
    output logic [DATA_W-1:0]   memOut,
    output logic                memValid,
    output logic                busy
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int NBYTES = DATA_W / 8;
    localparam int LAT    = clamp_lat(READ_LAT);

`ifdef DATA_MEMORY_CLEAR_EN
    localparam seq_state_t RST_STATE = CLEAR;
`else
    localparam seq_state_t RST_STATE = RUN;
`endif

    logic [DATA_W-1:0] mem [DEPTH];

    seq_state_t        state;
    seq_state_t        state_nx;
    logic [ADDR_W-1:0] clr_addr;
    logic [ADDR_W-1:0] clr_addr_nx;
    logic              clr_we;

    logic              accept;
    logic              wr_acc;
    logic              rd_acc;
    logic [DATA_W-1:0] rd_word;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state    <= RST_STATE;
            clr_addr <= '0;
        end else begin
            state    <= state_nx;
            clr_addr <= clr_addr_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        clr_addr_nx = clr_addr;
        clr_we      = 1'b0;
        unique case (state)
            CLEAR: begin
                clr_we      = 1'b1;
                clr_addr_nx = clr_addr + 1'b1;
                if (clr_addr == '1) state_nx = RUN;
            end
            RUN: begin
                state_nx = RUN;
            end
        endcase
    end

`ifdef DATA_MEMORY_CLEAR_EN
    assign busy = (state == CLEAR);
`else
    assign busy = 1'b0;
`endif

    assign memReady = ~busy;
    assign accept   = memReq & memReady;
    assign wr_acc   = accept & memWrite;
    assign rd_acc   = accept & ~memWrite;
    assign rd_word  = mem[addressMem];

    // Storage has no reset; the clear sequencer owns the port while busy.
    always_ff @(posedge clock) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_acc) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (byteEn[b]) mem[addressMem][b*8 +: 8] <= dataMem[b*8 +: 8];
            end
        end
    end

    mem_read_pipe #(
        .W   (DATA_W),
        .LAT (LAT)
    ) u_pipe (
        .clock     (clock),
        .resetN    (resetN),
        .req_valid (rd_acc),
        .req_data  (rd_word),
        .rsp_valid (memValid),
        .rsp_data  (memOut)
    );

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter DATA_W, default 8, word width in bits; SHALL be a multiple of 8, range 8..64.
REQ-002 Parameter ADDR_W, default 13, address width; depth SHALL be 2**ADDR_W words.
REQ-003 Parameter READ_LAT, default 1, read latency in cycles, range 1..4.
REQ-004 clock  in  1  sole clock; all state changes on its rising edge.
REQ-005 resetN  in  1  asynchronous, active-low reset.
REQ-006 memReq  in  1  request strobe, qualified by memReady.
REQ-007 memWrite  in  1  1 = write request, 0 = read request.
REQ-008 addressMem  in  ADDR_W  word address.
REQ-009 dataMem  in  DATA_W  write data.
REQ-010 byteEn  in  DATA_W/8  per-byte write enable; ignored on reads.
REQ-011 memReady  out  1  request acceptance; equals not busy.
REQ-012 memOut  out  DATA_W  registered read data.
REQ-013 memValid  out  1  one-cycle pulse marking memOut valid.
REQ-014 busy  out  1  high while the clear sequencer runs.

Function
REQ-015 A request SHALL be accepted on a rising edge where memReq=1 and memReady=1; otherwise it is dropped, never queued.
REQ-016 Accepted write SHALL update only the bytes with byteEn[i]=1 at that edge; byteEn=0 leaves the word unchanged.
REQ-017 Accepted read SHALL drive memOut and pulse memValid exactly READ_LAT cycles after acceptance.
REQ-018 Back-to-back reads SHALL be accepted every cycle, fully pipelined, with results returned in request order.
REQ-019 A read accepted one cycle after a write to the same address SHALL return the newly written data.
REQ-020 memOut SHALL hold its last value when memValid=0.
REQ-021 Address range is complete (2**ADDR_W words); no out-of-range case exists and the address has no wrap behaviour.
REQ-022 Sequencer states: CLEAR and RUN; CLEAR writes zero to one word per cycle from address 0 upward; after address 2**ADDR_W-1 it SHALL transition to RUN.
REQ-023 In CLEAR, busy=1 and memReady=0; in RUN, busy=0 and memReady=1.

Reset
REQ-024 On resetN=0: memOut=0, memValid=0, read pipeline flushed, clear counter=0.
REQ-025 Reset asserted mid-read SHALL cancel all in-flight reads; no memValid pulse follows deassertion.
REQ-026 Reset asserted mid-clear SHALL restart the clear from address 0.

Configuration
REQ-027 Macro DATA_MEMORY_CLEAR_EN defined: sequencer enters CLEAR on reset and runs per REQ-022/023 (busy for 2**ADDR_W cycles).
REQ-028 Macro undefined: sequencer enters RUN directly on reset, busy tied 0, contents are undefined at power-up and preserved across reset.

Structure
REQ-029 Package data_memory_pkg SHALL hold the sequencer state enum (CLEAR, RUN) and the READ_LAT range limits.
REQ-030 Sub-module mem_read_pipe SHALL implement the READ_LAT-stage data/valid delay line with asynchronous reset.

Verification
REQ-031 Macro on, DATA_W=8, ADDR_W=4: release reset -> busy=1 for 16 cycles, then memReady=1; read addresses 0..15 -> all return 0x00.
REQ-032 DATA_W=32: write 0xDEADBEEF to addr 5 with byteEn=1111, then write 0x00000011 with byteEn=0001 -> read addr 5 returns 0xDEADBE11.
REQ-033 READ_LAT=3: reads of addr 1,2,3 on consecutive cycles (contents 0xA1,0xA2,0xA3) -> memValid high on cycles 3,4,5 after the first acceptance with 0xA1,0xA2,0xA3 in order.
REQ-034 Write 0x5A to addr 7, read addr 7 on the next cycle -> memOut=0x5A after READ_LAT.
REQ-035 Read in flight at READ_LAT=2, resetN pulsed low one cycle later -> memValid never pulses, memOut=0; with macro on, busy reasserts and the clear restarts from addr 0.
REQ-036 memReq=1 during busy=1 with write 0xFF to addr 2 -> request dropped; after clear, addr 2 reads 0x00.
